input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner_pkg.sv | 13 +
 rtl/debounce_channel.sv | 76 +++++++
 rtl/input_conditioner.sv | 34 +++
 tb/tb_input_conditioner.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared defaults and helpers for the input conditioner: parameter defaults
// and the debounce counter width calculation.
package input_conditioner_pkg;

    localparam int DEF_WIDTH           = 32'd4;
    localparam int DEF_STAGES          = 32'd2;
    localparam int DEF_DEBOUNCE_CYCLES = 32'd16;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 32'd1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One conditioner channel: synchronizer chain, saturating debounce counter,
// debounced level register and registered rise/fall pulses.
module debounce_channel
    import input_conditioner_pkg::*;
#(
    parameter int STAGES          = DEF_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic sync_out,
    output logic stable_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [STAGES-1:0] sync_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_next_s;
    logic              stable_r;
    logic              rise_r;
    logic              fall_r;
    logic              level_s;
    logic              accept_s;

    // Synchronizer shift chain; bit STAGES-1 drives sync_out.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], raw_in};
        end
    end

    // Debounce decision. The counter judges the level being loaded into the
    // last sync flop, so the disagreement is counted on the edge it appears
    // at sync_out and acceptance lands STAGES+DEBOUNCE_CYCLES-1 edges in.
    always_comb begin
        level_s      = sync_r[STAGES-2];
        accept_s     = 1'b0;
        count_next_s = '0;
        if (level_s == stable_r) begin
            count_next_s = '0;
        end else if (count_r == CNT_LAST) begin
            accept_s     = 1'b1;
            count_next_s = '0;
        end else begin
            count_next_s = count_r + CNT_W'(1);
        end
    end

    // Counter, debounced level and edge pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r  <= '0;
            stable_r <= 1'b0;
            rise_r   <= 1'b0;
            fall_r   <= 1'b0;
        end else begin
            count_r  <= count_next_s;
            stable_r <= accept_s ? level_s : stable_r;
            rise_r   <= accept_s & level_s;
            fall_r   <= accept_s & ~level_s;
        end
    end

    assign sync_out   = sync_r[STAGES-1];
    assign stable_out = stable_r;
    assign rise_pulse = rise_r;
    assign fall_pulse = fall_r;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: WIDTH independent synchronize-and-debounce
// channels with registered edge pulses.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int STAGES          = DEF_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] stable_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_channel #(
            .STAGES          (STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .raw_in     (raw_in[i]),
            .sync_out   (sync_out[i]),
            .stable_out (stable_out[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed self-checking bench for input_conditioner with WIDTH=4, STAGES=2,
// DEBOUNCE_CYCLES=4 (accepted changes appear five edges after first sample).
module tb_input_conditioner;

    logic       clk;
    logic       reset;
    logic [3:0] raw_in;
    logic [3:0] sync_out;
    logic [3:0] stable_out;
    logic [3:0] rise_pulse;
    logic [3:0] fall_pulse;

    int tests = 0;
    int fails = 0;

    input_conditioner #(
        .WIDTH           (4),
        .STAGES          (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .raw_in     (raw_in),
        .sync_out   (sync_out),
        .stable_out (stable_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        reset  = 1'b0;
        raw_in = 4'b0000;
        tick(2);
        check("reset_sync",   sync_out,   4'b0000);
        check("reset_stable", stable_out, 4'b0000);
        check("reset_rise",   rise_pulse, 4'b0000);
        check("reset_fall",   fall_pulse, 4'b0000);
        reset = 1'b1;
        tick(1);

        // Clean step on bit 0
        raw_in = 4'b0001;
        tick(1);
        check("step_sync_e1", sync_out, 4'b0000);
        tick(1);
        check("step_sync_e2", sync_out, 4'b0001);
        tick(2);
        check("step_stable_e4", stable_out, 4'b0000);
        check("step_rise_e4",   rise_pulse, 4'b0000);
        tick(1);
        check("step_stable_e5", stable_out, 4'b0001);
        check("step_rise_e5",   rise_pulse, 4'b0001);
        tick(1);
        check("step_rise_e6",   rise_pulse, 4'b0000);
        check("step_stable_e6", stable_out, 4'b0001);

        // Three-cycle glitch on bit 1
        raw_in = 4'b0011;
        tick(3);
        raw_in = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("glitch_stable", stable_out, 4'b0001);
            check("glitch_rise",   rise_pulse, 4'b0000);
            check("glitch_fall",   fall_pulse, 4'b0000);
        end

        // Bounce on bit 2: 1,0,1,0 then held 1
        for (int i = 0; i < 4; i++) begin
            raw_in[2] = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick(1);
            check("bounce_rise_early", rise_pulse, 4'b0000);
        end
        raw_in[2] = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            check("bounce_rise_wait", rise_pulse, 4'b0000);
        end
        tick(1);
        check("bounce_rise_e5",   rise_pulse, 4'b0100);
        check("bounce_stable_e5", stable_out, 4'b0101);
        tick(1);
        check("bounce_rise_e6",   rise_pulse, 4'b0000);

        // Release on bit 3
        raw_in = 4'b1101;
        tick(6);
        check("release_setup", stable_out, 4'b1101);
        raw_in = 4'b0101;
        tick(4);
        check("release_fall_e4",   fall_pulse, 4'b0000);
        check("release_stable_e4", stable_out, 4'b1101);
        tick(1);
        check("release_fall_e5",   fall_pulse, 4'b1000);
        check("release_stable_e5", stable_out, 4'b0101);
        check("release_rise_e5",   rise_pulse, 4'b0000);
        tick(1);
        check("release_fall_e6",   fall_pulse, 4'b0000);

        // Reset in the middle of a count
        reset  = 1'b0;
        raw_in = 4'b0000;
        tick(1);
        reset = 1'b1;
        tick(1);
        raw_in = 4'hF;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("midrst_sync",   sync_out,   4'b0000);
        check("midrst_stable", stable_out, 4'b0000);
        check("midrst_rise",   rise_pulse, 4'b0000);
        check("midrst_fall",   fall_pulse, 4'b0000);
        reset = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            check("midrst_rise_wait", rise_pulse, 4'b0000);
        end
        tick(1);
        check("midrst_rise_e5",   rise_pulse, 4'hF);
        check("midrst_stable_e5", stable_out, 4'hF);
        tick(1);
        check("midrst_rise_e6",   rise_pulse, 4'b0000);

        // Independent simultaneous changes on bits 0 and 2
        reset  = 1'b0;
        raw_in = 4'b0000;
        tick(1);
        reset  = 1'b1;
        raw_in = 4'b0101;
        for (int i = 1; i <= 7; i++) begin
            tick(1);
            check("indep_rise",   rise_pulse, (i == 5) ? 4'b0101 : 4'b0000);
            check("indep_stable", stable_out, (i >= 5) ? 4'b0101 : 4'b0000);
            check("indep_fall",   fall_pulse, 4'b0000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
